subtractor_seq: RTL and testbench

SUBTRACTOR_SEQ -- requirements
Module: subtractor_seq

---
 rtl/subtractor_seq_if.sv | 45 ++++
 rtl/subtractor_seq.sv | 144 ++++++++++++++
 tb/tb_subtractor_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/subtractor_seq_if.sv
// Handshake bundle for subtractor_seq: operand channel in, result channel out.
// The slave modport is the subtractor's view; master is the producer/consumer side.
interface subtractor_seq_if #(
   parameter int WIDTH = 8
);
   // Operand channel
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] din_one;
   logic [WIDTH-1:0] din_two;
   logic             bin;

   // Result channel
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport slave (
      input  in_valid,
      output in_ready,
      input  din_one,
      input  din_two,
      input  bin,
      output out_valid,
      input  out_ready,
      output diff,
      output bout,
      output ovf
   );

   modport master (
      output in_valid,
      input  in_ready,
      output din_one,
      output din_two,
      output bin,
      input  out_valid,
      output out_ready,
      input  diff,
      input  bout,
      input  ovf
   );
endinterface

// File: rtl/subtractor_seq.sv
// Serial subtractor: computes din_one - din_two - bin two bits per clock,
// LSB slice first, behind a valid/ready handshake on both sides.
// One operation in flight; result takes WIDTH/2 cycles after acceptance.
module subtractor_seq #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   subtractor_seq_if.slave bus
);

   localparam int SLICES = WIDTH / 2;
   localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Latched operands; only written on the accept edge.
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             bin_reg;

   // Slice engine state.
   logic [CW-1:0]    cnt;
   logic             borrow_reg;
   logic [WIDTH-1:0] part_reg;

   // Result registers, held until the next DONE entry.
   logic [WIDTH-1:0] diff_reg;
   logic             bout_reg;
   logic             ovf_reg;

   // Combinational datapath.
   logic             accept;
   logic             consume;
   logic             last_slice;
   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic             borrow_in;
   logic [2:0]       slice_res;
   logic [WIDTH-1:0] res_full;
   logic             ovf_full;

   // Handshake flags decode straight from the registered state.
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);

   assign accept     = bus.in_valid && (state == IDLE);
   assign consume    = (state == DONE) && bus.out_ready;
   assign last_slice = (cnt == LAST_SLICE);

   // Current slice: shift the operand so the active pair lands at [1:0].
   assign a_shift   = a_reg >> {cnt, 1'b0};
   assign b_shift   = b_reg >> {cnt, 1'b0};
   assign borrow_in = (cnt == '0) ? bin_reg : borrow_reg;

   // 3-bit subtract; bit 2 goes high exactly when the slice underflows.
   assign slice_res = {1'b0, a_shift[1:0]} - {1'b0, b_shift[1:0]} - {2'b00, borrow_in};

   // Merge the current slice into the partial result.
   always_comb begin
      // NOTE: default first so every path assigns res_full and no latch is inferred.
      res_full = part_reg;
      res_full[{cnt, 1'b0} +: 2] = slice_res[1:0];
   end

   // Signed overflow: operand signs differ and the result sign disagrees with a.
   assign ovf_full = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                     (res_full[WIDTH-1] != a_reg[WIDTH-1]);

   // Next-state logic for IDLE -> CALC -> DONE -> IDLE.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (accept) state_next = CALC;
         CALC: if (last_slice) state_next = DONE;
         DONE: if (consume) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset forces IDLE so in_ready rises without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Operand capture, only on the accept edge; other cycles ignore the inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every datapath register is reset so an aborted operation leaves no residue.
      if (!rst_n) begin
         a_reg   <= '0;
         b_reg   <= '0;
         bin_reg <= 1'b0;
      end else if (accept) begin
         a_reg   <= bus.din_one;
         b_reg   <= bus.din_two;
         bin_reg <= bus.bin;
      end
   end

   // Slice engine: one 2-bit slice per CALC edge, counter held at the last slice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         borrow_reg <= 1'b0;
         part_reg   <= '0;
      end else if (accept) begin
         cnt        <= '0;
         borrow_reg <= 1'b0;
         part_reg   <= '0;
      end else if (state == CALC) begin
         part_reg   <= res_full;
         borrow_reg <= slice_res[2];
         if (!last_slice) cnt <= cnt + 1'b1;
      end
   end

   // Result registers load on the final slice edge and hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_reg <= '0;
         bout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else if ((state == CALC) && last_slice) begin
         diff_reg <= res_full;
         bout_reg <= slice_res[2];
         ovf_reg  <= ovf_full;
      end
   end

   assign bus.diff = diff_reg;
   assign bus.bout = bout_reg;
   assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_subtractor_seq.sv
// Directed and random-vector bench for subtractor_seq at WIDTH = 8.
module tb_subtractor_seq;

   localparam int WIDTH = 8;

   logic clk;
   logic rst_n;
   int   tests;
   int   failed;

   subtractor_seq_if #(.WIDTH(WIDTH)) bus ();

   subtractor_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one operation, verify exact latency and result, then consume it.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] e_diff, input logic e_bout, input logic e_ovf);
      check({tag, "_in_ready"}, bus.in_ready, 1'b1);
      bus.in_valid = 1'b1;
      bus.din_one  = a;
      bus.din_two  = b;
      bus.bin      = bi;
      step();
      bus.in_valid = 1'b0;
      bus.din_one  = ~a;
      bus.din_two  = ~b;
      bus.bin      = ~bi;
      for (int k = 1; k <= 4; k++) begin
         if (k < 4) check({tag, "_calc_busy"}, {bus.out_valid, bus.in_ready}, 2'b00);
         step();
      end
      check({tag, "_lat_valid"}, bus.out_valid, 1'b1);
      check({tag, "_diff"}, bus.diff, e_diff);
      check({tag, "_bout"}, bus.bout, e_bout);
      check({tag, "_ovf"},  bus.ovf,  e_ovf);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check({tag, "_idle"}, {bus.out_valid, bus.in_ready}, 2'b01);
   endtask

   logic [7:0] ra;
   logic [7:0] rb;
   logic       rbi;
   logic [8:0] model;
   logic       m_ovf;

   initial begin
      tests  = 0;
      failed = 0;
      rst_n  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.din_one   = '0;
      bus.din_two   = '0;
      bus.bin       = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      check("rst_flags", {bus.out_valid, bus.in_ready}, 2'b01);
      check("rst_diff", bus.diff, 8'h00);
      check("rst_bout_ovf", {bus.bout, bus.ovf}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Directed arithmetic cases.
      run_op("sub5a3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
      run_op("sub0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run_op("sub8001", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op("sub100f", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
      run_op("sub0f0f", 8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0);

      // Backpressure: 7F - FF, with noise on the operand channel throughout.
      bus.in_valid = 1'b1;
      bus.din_one  = 8'h7F;
      bus.din_two  = 8'hFF;
      bus.bin      = 1'b0;
      step();
      for (int k = 0; k < 4; k++) begin
         bus.din_one = 8'h11 * k[7:0];
         bus.din_two = 8'hA5;
         bus.bin     = 1'b1;
         step();
      end
      for (int k = 0; k < 5; k++) begin
         check("bp_flags", {bus.out_valid, bus.in_ready}, 2'b10);
         check("bp_diff", bus.diff, 8'h80);
         check("bp_bout_ovf", {bus.bout, bus.ovf}, 2'b11);
         bus.in_valid = k[0];
         bus.din_one  = 8'h33;
         bus.din_two  = 8'h01;
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
      check("bp_retain", {bus.diff, bus.bout, bus.ovf}, {8'h80, 1'b1, 1'b1});

      // Reset during the second CALC cycle.
      bus.in_valid = 1'b1;
      bus.din_one  = 8'hC3;
      bus.din_two  = 8'h12;
      step();
      bus.in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_flags", {bus.out_valid, bus.in_ready}, 2'b01);
      check("mid_rst_outs", {bus.diff, bus.bout, bus.ovf}, 10'h000);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check("mid_rst_no_valid", bus.out_valid, 1'b0);
         step();
      end
      run_op("sub0101", 8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);

      // Back-to-back random operations with in_valid and out_ready held high.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rbi = 1'($urandom);
         model = {1'b0, ra} - {1'b0, rb} - {8'h00, rbi};
         m_ovf = (ra[7] != rb[7]) && (model[7] != ra[7]);
         check("b2b_ready", bus.in_ready, 1'b1);
         bus.in_valid = 1'b1;
         bus.din_one  = ra;
         bus.din_two  = rb;
         bus.bin      = rbi;
         step();
         bus.din_one  = ~ra;
         bus.din_two  = ra ^ rb;
         bus.bin      = ~rbi;
         for (int k = 0; k < 3; k++) step();
         check("b2b_early", bus.out_valid, 1'b0);
         step();
         check("b2b_result", {bus.out_valid, bus.diff, bus.bout, bus.ovf},
               {1'b1, model[7:0], model[8], m_ovf});
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("b2b_end_idle", {bus.out_valid, bus.in_ready}, 2'b01);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
